// File: rtl/sdram_chip_model.sv
// SDR SDRAM responder (MT48LC16M16 subset): decodes controller commands, tracks open rows,
// serves CL-delayed single-word reads and byte-masked writes from a block-RAM store.
module sdram_chip_model #(
  parameter int MEM_AW = 12,
  parameter int TRCD   = 3
) (
  input  logic        clk,
  input  logic        init,
  inout  wire  [15:0] SDRAM_DQ,
  input  logic [12:0] SDRAM_A,
  input  logic [1:0]  SDRAM_BA,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic        SDRAM_CKE,
  output logic        mode_set,
  output logic [15:0] refresh_cnt,
  output logic        err,
  output logic [2:0]  err_code
);

  // state     | meaning
  // UNINIT    | after reset, waiting for PRECHARGE all
  // PRE_DONE  | all banks precharged, waiting for LOAD_MODE
  // READY     | mode programmed, ACTIVE/READ/WRITE accepted
  typedef enum logic [1:0] {
    ST_UNINIT   = 2'd0,
    ST_PRE_DONE = 2'd1,
    ST_READY    = 2'd2
  } state_t;

  localparam int TW    = $clog2(TRCD + 1);
  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [TW-1:0] TRCD_LOAD = TW'(TRCD - 1);

  localparam logic [2:0] CMD_LOAD_MODE = 3'b000;
  localparam logic [2:0] CMD_REFRESH   = 3'b001;
  localparam logic [2:0] CMD_PRECHARGE = 3'b010;
  localparam logic [2:0] CMD_ACTIVE    = 3'b011;
  localparam logic [2:0] CMD_WRITE     = 3'b100;
  localparam logic [2:0] CMD_READ      = 3'b101;

  state_t state, state_next;

  logic [3:0]    bank_open;
  logic [12:0]   open_row [4];
  logic [TW-1:0] trcd_cnt [4];
  logic          cl3;

  logic          s1_v, s2_v, s3_v, out_v;
  logic [1:0]    s1_dqm, s2_dqm, s3_dqm, out_dqm;
  logic [15:0]   rd_word, s2_data, s3_data, out_data;

  logic [7:0]    mem_lo [DEPTH];
  logic [7:0]    mem_hi [DEPTH];

  logic              cmd_en;
  logic [2:0]        cmd;
  logic              any_open;
  logic              rd_pending;
  logic              mode_bad;
  logic [23:0]       addr_full;
  logic [MEM_AW-1:0] mem_addr;
  logic              unused_bits;

  logic       do_act, do_rd, do_wr, do_pre, do_lm, do_ref;
  logic [2:0] err_new;

  assign cmd_en     = SDRAM_CKE & ~SDRAM_nCS;
  assign cmd        = {SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE};
  assign any_open   = |bank_open;
  assign rd_pending = s1_v | s2_v | s3_v | out_v;
  assign mode_bad   = (SDRAM_A[2:0] != 3'b000) ||
                      !((SDRAM_A[6:4] == 3'd2) || (SDRAM_A[6:4] == 3'd3));
  // Full {BA,row,col} word address; the store only keeps the low MEM_AW bits.
  assign addr_full   = {SDRAM_BA, open_row[SDRAM_BA], SDRAM_A[8:0]};
  assign mem_addr    = addr_full[MEM_AW-1:0];
  assign unused_bits = ^addr_full;

  always_ff @(posedge clk) begin
    if (init) state <= ST_UNINIT;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    err_new    = 3'd0;
    do_act     = 1'b0;
    do_rd      = 1'b0;
    do_wr      = 1'b0;
    do_pre     = 1'b0;
    do_lm      = 1'b0;
    do_ref     = 1'b0;
    if (cmd_en) begin
      case (cmd)
        CMD_ACTIVE: begin
          if (state != ST_READY) err_new = 3'd1;
          else begin
            do_act = 1'b1;
            if (bank_open[SDRAM_BA]) err_new = 3'd3;
          end
        end
        CMD_READ, CMD_WRITE: begin
          if (state != ST_READY)          err_new = 3'd1;
          else if (!bank_open[SDRAM_BA])  err_new = 3'd4;
          else begin
            do_rd = (cmd == CMD_READ);
            do_wr = (cmd == CMD_WRITE);
            if (trcd_cnt[SDRAM_BA] != '0)  err_new = 3'd5;
            else if (do_wr && rd_pending)  err_new = 3'd6;
          end
        end
        CMD_PRECHARGE: begin
          do_pre = 1'b1;
          if (SDRAM_A[10] && state == ST_UNINIT) state_next = ST_PRE_DONE;
        end
        CMD_REFRESH: begin
          do_ref = 1'b1;
          if (any_open) err_new = 3'd7;
        end
        CMD_LOAD_MODE: begin
          if (state != ST_UNINIT) begin
            do_lm      = 1'b1;
            state_next = ST_READY;
            if (mode_bad || any_open) err_new = 3'd2;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      bank_open   <= '0;
      mode_set    <= 1'b0;
      refresh_cnt <= '0;
      err         <= 1'b0;
      err_code    <= 3'd0;
      cl3         <= 1'b0;
      s1_v        <= 1'b0;
      s2_v        <= 1'b0;
      s3_v        <= 1'b0;
      out_v       <= 1'b0;
      for (int b = 0; b < 4; b++) trcd_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (do_act && SDRAM_BA == 2'(b)) trcd_cnt[b] <= TRCD_LOAD;
        else if (trcd_cnt[b] != '0)      trcd_cnt[b] <= trcd_cnt[b] - TW'(1);
      end

      if (do_act) begin
        bank_open[SDRAM_BA] <= 1'b1;
        open_row[SDRAM_BA]  <= SDRAM_A;
      end
      if ((do_rd || do_wr) && SDRAM_A[10]) bank_open[SDRAM_BA] <= 1'b0;
      if (do_pre) begin
        if (SDRAM_A[10]) bank_open <= '0;
        else             bank_open[SDRAM_BA] <= 1'b0;
      end

      if (do_lm) begin
        mode_set <= 1'b1;
        cl3      <= !mode_bad && (SDRAM_A[6:4] == 3'd3);
      end
      if (do_ref) refresh_cnt <= refresh_cnt + 16'd1;

      if (!err && err_new != 3'd0) begin
        err      <= 1'b1;
        err_code <= err_new;
      end

      // s2 holds a word 2 edges after READ, s3 only exists for CL=3.
      s1_v  <= do_rd;
      s2_v  <= s1_v;
      s3_v  <= s2_v & cl3;
      out_v <= cl3 ? s3_v : s2_v;
    end
  end

  always_ff @(posedge clk) begin
    s1_dqm   <= {SDRAM_DQMH, SDRAM_DQML};
    s2_dqm   <= s1_dqm;
    s2_data  <= rd_word;
    s3_dqm   <= s2_dqm;
    s3_data  <= s2_data;
    out_dqm  <= cl3 ? s3_dqm : s2_dqm;
    out_data <= cl3 ? s3_data : s2_data;
  end

  always_ff @(posedge clk) begin
    if (do_wr && !init) begin
      if (!SDRAM_DQML) mem_lo[mem_addr] <= SDRAM_DQ[7:0];
      if (!SDRAM_DQMH) mem_hi[mem_addr] <= SDRAM_DQ[15:8];
    end
    rd_word <= {mem_hi[mem_addr], mem_lo[mem_addr]};
  end

  assign SDRAM_DQ[7:0]  = (out_v && !out_dqm[0]) ? out_data[7:0]  : 8'bz;
  assign SDRAM_DQ[15:8] = (out_v && !out_dqm[1]) ? out_data[15:8] : 8'bz;

endmodule

// File: tb/tb_sdram_chip_model.sv
// Randomized bench for sdram_chip_model: a timestamp-based reference model feeds status and
// read-data scoreboards that a negedge monitor checks against the pins.
module tb_sdram_chip_model;
  localparam int MEM_AW = 12;
  localparam int TRCD   = 3;

  localparam int K_NOP = 0, K_ACT = 1, K_RD = 2, K_WR = 3, K_PRE = 4, K_REF = 5, K_LM = 6, K_BST = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        init;
  logic [12:0] a;
  logic [1:0]  ba;
  logic        dqml, dqmh, ncs, nras, ncas, nwe, cke;
  logic        tb_drv;
  logic [15:0] tb_dq;
  wire  [15:0] dq;
  logic        mode_set, err;
  logic [15:0] refresh_cnt;
  logic [2:0]  err_code;

  assign dq = tb_drv ? tb_dq : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup pu (dq[i]);
  end

  sdram_chip_model #(.MEM_AW(MEM_AW), .TRCD(TRCD)) dut (
    .clk(clk), .init(init), .SDRAM_DQ(dq), .SDRAM_A(a), .SDRAM_BA(ba),
    .SDRAM_DQML(dqml), .SDRAM_DQMH(dqmh), .SDRAM_nCS(ncs), .SDRAM_nRAS(nras),
    .SDRAM_nCAS(ncas), .SDRAM_nWE(nwe), .SDRAM_CKE(cke), .mode_set(mode_set),
    .refresh_cnt(refresh_cnt), .err(err), .err_code(err_code)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [15:0] val; logic [15:0] care; } rd_t;
  typedef struct { int due; logic ms; logic [15:0] rc; logic e; logic [2:0] ec; } st_t;
  rd_t rdq[$];
  st_t stq[$];

  // Reference model state, expressed in edge timestamps.
  bit          m_pre, m_ready, m_mode, m_err;
  int          m_cl, m_code, m_rd_end;
  bit          m_open [4];
  logic [12:0] m_row  [4];
  int          m_act  [4];
  logic [15:0] m_ref;
  logic [7:0]  m_lo [int];
  logic [7:0]  m_hi [int];
  bit          safe_wr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [2:0] pins(int k);
    case (k)
      K_ACT:   return 3'b011;
      K_RD:    return 3'b101;
      K_WR:    return 3'b100;
      K_PRE:   return 3'b010;
      K_REF:   return 3'b001;
      K_LM:    return 3'b000;
      K_BST:   return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  function automatic int word_key(logic [1:0] b, logic [12:0] row, logic [8:0] col);
    return (int'(b) * (1 << 22) + int'(row) * 512 + int'(col)) % (1 << MEM_AW);
  endfunction

  function automatic void model_reset(int r);
    rd_t keep[$];
    m_pre = 0; m_ready = 0; m_mode = 0; m_err = 0; m_code = 0; m_cl = 2; m_ref = 0;
    m_rd_end = r;
    for (int i = 0; i < 4; i++) m_open[i] = 0;
    foreach (rdq[i]) if (rdq[i].due < r) keep.push_back(rdq[i]);
    rdq = keep;
  endfunction

  function automatic void model_cmd(int k, logic [1:0] b, logic [12:0] ad, logic [1:0] m,
                                    logic [15:0] d, int r);
    int code = 0;
    int key;
    bit any = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    bit bad;
    rd_t e;
    case (k)
      K_ACT: begin
        if (!m_ready) code = 1;
        else begin
          if (m_open[b]) code = 3;
          m_open[b] = 1; m_row[b] = ad; m_act[b] = r;
        end
      end
      K_RD, K_WR: begin
        if (!m_ready) code = 1;
        else if (!m_open[b]) code = 4;
        else begin
          if (r - m_act[b] < TRCD) code = 5;
          else if (k == K_WR && r <= m_rd_end) code = 6;
          key = word_key(b, m_row[b], ad[8:0]);
          if (k == K_WR) begin
            if (!m[0]) m_lo[key] = d[7:0];
            if (!m[1]) m_hi[key] = d[15:8];
          end else begin
            e.due = r + m_cl;
            e.val = 16'hffff;
            e.care = 16'h0000;
            if (m[0]) e.care[7:0] = 8'hff;
            else if (m_lo.exists(key)) begin e.val[7:0] = m_lo[key]; e.care[7:0] = 8'hff; end
            if (m[1]) e.care[15:8] = 8'hff;
            else if (m_hi.exists(key)) begin e.val[15:8] = m_hi[key]; e.care[15:8] = 8'hff; end
            rdq.push_back(e);
            if (r + m_cl + 1 > m_rd_end) m_rd_end = r + m_cl + 1;
          end
          if (ad[10]) m_open[b] = 0;
        end
      end
      K_PRE: begin
        if (ad[10]) begin
          for (int i = 0; i < 4; i++) m_open[i] = 0;
          m_pre = 1;
        end else m_open[b] = 0;
      end
      K_REF: begin
        m_ref = m_ref + 16'd1;
        if (any) code = 7;
      end
      K_LM: begin
        if (m_pre) begin
          bad = (ad[2:0] != 3'd0) || !(ad[6:4] == 3'd2 || ad[6:4] == 3'd3);
          m_cl = bad ? 2 : int'(ad[6:4]);
          m_ready = 1; m_mode = 1;
          if (bad || any) code = 2;
        end
      end
      default: ;
    endcase
    if (!m_err && code != 0) begin m_err = 1; m_code = code; end
  endfunction

  task automatic drive(int k, logic [1:0] b, logic [12:0] ad, logic [1:0] m, logic [15:0] d,
                       bit cs_on, bit cke_on, bit rst);
    int r;
    st_t s;
    @(posedge clk);
    #1;
    r = cyc + 1;
    if (safe_wr && k == K_WR && r <= m_rd_end) k = K_NOP;
    init = rst;
    {nras, ncas, nwe} = pins(k);
    ncs = !cs_on; cke = cke_on; ba = b; a = ad; {dqmh, dqml} = m;
    tb_dq = d;
    tb_drv = (k == K_WR) && cs_on && cke_on && !rst;
    if (rst) model_reset(r);
    else if (cs_on && cke_on) model_cmd(k, b, ad, m, d, r);
    s.due = r; s.ms = m_mode; s.rc = m_ref; s.e = m_err; s.ec = 3'(m_code);
    stq.push_back(s);
  endtask

  task automatic c(int k, logic [1:0] b = 2'd0, logic [12:0] ad = 13'd0, logic [1:0] m = 2'b00,
                   logic [15:0] d = 16'h0000);
    drive(k, b, ad, m, d, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic rst();
    drive(K_NOP, 2'd0, 13'd0, 2'b00, 16'h0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++) c(K_NOP);
  endtask

  // Monitor: pops expectations when their edge has passed and compares the pins.
  initial begin
    st_t s;
    rd_t e;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        while (stq.size() > 0 && stq[0].due <= cyc) begin
          s = stq.pop_front();
          n_cmp++;
          if (s.due != cyc || mode_set !== s.ms || refresh_cnt !== s.rc ||
              err !== s.e || err_code !== s.ec) begin
            n_bad++;
            $display("FAIL status @%0d (due %0d): got ms=%0b rc=%0d err=%0b code=%0d, want ms=%0b rc=%0d err=%0b code=%0d",
                     cyc, s.due, mode_set, refresh_cnt, err, err_code, s.ms, s.rc, s.e, s.ec);
          end
        end
        if (rdq.size() > 0 && rdq[0].due <= cyc) begin
          e = rdq.pop_front();
          if (e.care != 16'h0000) begin
            n_cmp++;
            if (e.due != cyc || (dq & e.care) !== (e.val & e.care)) begin
              n_bad++;
              $display("FAIL read_data @%0d (due %0d): got %h want %h care %h",
                       cyc, e.due, dq, e.val, e.care);
            end
          end
        end else if (!tb_drv) begin
          n_cmp++;
          if (dq !== 16'hffff) begin
            n_bad++;
            $display("FAIL bus_idle @%0d: got %h want ffff", cyc, dq);
          end
        end
      end
    end
  end

  initial begin
    int op;
    logic [1:0] rb;
    init = 1'b1; a = '0; ba = '0; dqml = 0; dqmh = 0; ncs = 1; nras = 1; ncas = 1; nwe = 1;
    cke = 1; tb_drv = 0; tb_dq = '0;
    model_reset(0);
    repeat (2) @(posedge clk);

    rst();
    c(K_PRE, 0, 13'h400); c(K_LM, 0, 13'h220);
    repeat (3) c(K_REF);

    c(K_ACT, 1, 13'h0123); nops(2); c(K_WR, 1, 13'h405, 2'b00, 16'hA55A);
    c(K_ACT, 1, 13'h0123); nops(2); c(K_RD, 1, 13'h405); nops(3);
    c(K_ACT, 1, 13'h0123); nops(2); c(K_WR, 1, 13'h405, 2'b10, 16'h1234);
    c(K_ACT, 1, 13'h0123); nops(2); c(K_RD, 1, 13'h405); nops(3);
    c(K_ACT, 1, 13'h0123); nops(2); c(K_RD, 1, 13'h405, 2'b01); nops(3);

    c(K_ACT, 1, 13'h0123); nops(1); c(K_RD, 1, 13'h005); nops(3);
    c(K_PRE, 1, 13'h000); nops(1); c(K_RD, 1, 13'h005); nops(2);

    rst(); c(K_ACT, 0, 13'h0010); nops(2);
    rst(); nops(2);

    c(K_PRE, 0, 13'h400); c(K_LM, 0, 13'h230);
    c(K_ACT, 2, 13'h0005); nops(2);
    c(K_WR, 2, 13'h010, 2'b00, 16'(($urandom & 16'hfefe) | 16'h0101));
    c(K_WR, 2, 13'h011, 2'b00, 16'(($urandom & 16'hfefe) | 16'h0101));
    c(K_RD, 2, 13'h010); c(K_RD, 2, 13'h011); nops(5);

    rst(); c(K_PRE, 0, 13'h400); c(K_LM, 0, 13'h220);
    c(K_ACT, 3, 13'h0007); nops(2);
    c(K_WR, 3, 13'h001, 2'b00, 16'h5AA5); c(K_RD, 3, 13'h001); c(K_WR, 3, 13'h002, 2'b00, 16'h0F0F);
    nops(4);

    safe_wr = 1'b1;
    for (int round = 0; round < 6; round++) begin
      rst(); c(K_PRE, 0, 13'h400);
      c(K_LM, 0, ($urandom_range(0, 1) == 1) ? 13'h030 : 13'h020);
      for (int i = 0; i < 70; i++) begin
        op = $urandom_range(0, 99);
        rb = 2'($urandom);
        if (op < 18)      c(K_ACT, rb, 13'($urandom));
        else if (op < 45) c(K_RD, rb, {2'($urandom), ($urandom_range(0, 3) == 0), 6'd0, 4'($urandom)}, 2'($urandom));
        else if (op < 65) c(K_WR, rb, {2'($urandom), ($urandom_range(0, 3) == 0), 6'd0, 4'($urandom)}, 2'($urandom), 16'($urandom));
        else if (op < 75) c(K_PRE, rb, {2'b0, 1'($urandom), 10'd0});
        else if (op < 80) c(K_REF);
        else if (op < 88) c(K_NOP);
        else if (op < 92) c(K_BST, rb, 13'($urandom));
        else if (op < 96) drive($urandom_range(1, 5), rb, 13'($urandom), 2'b00, 16'h0, 1'b1, 1'b0, 1'b0);
        else              drive($urandom_range(1, 5), rb, 13'($urandom), 2'b00, 16'h0, 1'b0, 1'b1, 1'b0);
      end
      nops(6);
    end

    nops(8);
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (stq.size() != 0 || rdq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d status / %0d reads outstanding, want 0 / 0", stq.size(), rdq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
